// File: rtl/mips_pkg.sv
// ============================================================================
// Module : mips_pkg
// Desc   : Shared MIPS opcode / ALUOp constants and main-control decode helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam int REG_AW = 5;

   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       branch_ne;
      logic [1:0] alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

   function automatic ctrl_t decode_ctrl(input logic [5:0] op);
      ctrl_t c;
      c = CTRL_NOP;
      case (op)
         OP_RTYPE: begin
            c.reg_dst   = 1'b1;
            c.reg_write = 1'b1;
            c.alu_op    = ALUOP_FUNCT;
         end
         OP_LW: begin
            c.alu_src    = 1'b1;
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
            c.mem_read   = 1'b1;
            c.alu_op     = ALUOP_ADD;
         end
         OP_SW: begin
            c.alu_src   = 1'b1;
            c.mem_write = 1'b1;
            c.alu_op    = ALUOP_ADD;
         end
         OP_BEQ: begin
            c.branch = 1'b1;
            c.alu_op = ALUOP_SUB;
         end
         OP_BNE: begin
            c.branch_ne = 1'b1;
            c.alu_op    = ALUOP_SUB;
         end
         OP_ADDI: begin
            c.alu_src   = 1'b1;
            c.reg_write = 1'b1;
            c.alu_op    = ALUOP_ADD;
         end
         default: c = CTRL_NOP;
      endcase
      return c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/decode_stage_reg_file.sv
// ============================================================================
// Module : reg_file
// Desc   : 2R/1W register file, r0 hardwired zero, synchronous clear.
//          Optional same-cycle write-back bypass under macro WB_BYPASS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file
   import mips_pkg::*;
#(
   parameter int NREGS = 32,
   parameter int DW    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [REG_AW-1:0] i_waddr,
   input  logic [DW-1:0]     i_wdata,
   input  logic [REG_AW-1:0] i_raddr1,
   input  logic [REG_AW-1:0] i_raddr2,
   output logic [DW-1:0]     o_rdata1,
   output logic [DW-1:0]     o_rdata2
);

   // r0 has no storage; reads of it are forced to zero below
   logic [DW-1:0] r_regs [1:NREGS-1];

   logic          w_wr_ok;
   logic [DW-1:0] w_stored1;
   logic [DW-1:0] w_stored2;

   assign w_wr_ok = i_we && (i_waddr != '0) && (int'(i_waddr) < NREGS);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_ok) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   always_comb begin
      w_stored1 = '0;
      w_stored2 = '0;
      if ((i_raddr1 != '0) && (int'(i_raddr1) < NREGS)) w_stored1 = r_regs[i_raddr1];
      if ((i_raddr2 != '0) && (int'(i_raddr2) < NREGS)) w_stored2 = r_regs[i_raddr2];
   end

`ifdef WB_BYPASS_EN
   // Write-first/read-second emulation; suppressed in reset since the write is dropped
   logic w_byp1;
   logic w_byp2;
   assign w_byp1   = !rst && w_wr_ok && (i_waddr == i_raddr1);
   assign w_byp2   = !rst && w_wr_ok && (i_waddr == i_raddr2);
   assign o_rdata1 = w_byp1 ? i_wdata : w_stored1;
   assign o_rdata2 = w_byp2 ? i_wdata : w_stored2;
`else
   assign o_rdata1 = w_stored1;
   assign o_rdata2 = w_stored2;
`endif

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
// Module : decode_stage
// Desc   : MIPS ID stage: register file, main control, sign extend, load-use
//          stall with bubble insertion. Macro WB_BYPASS_EN enables WB bypass.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module decode_stage
   import mips_pkg::*;
#(
   parameter int NREGS = 32,
   parameter int DW    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       instr,
   input  logic [DW-1:0]     pc4,
   input  logic              wb_we,
   input  logic [4:0]        wb_addr,
   input  logic [DW-1:0]     wb_data,
   input  logic              ex_memread,
   input  logic [4:0]        ex_rt,
   output logic              RegDst,
   output logic              ALUSrc,
   output logic              MemtoReg,
   output logic              RegWrite,
   output logic              MemRead,
   output logic              MemWrite,
   output logic              Branch,
   output logic              BranchNE,
   output logic [1:0]        ALUOp,
   output logic [DW-1:0]     pc4o,
   output logic [DW-1:0]     rd1,
   output logic [DW-1:0]     rd2,
   output logic [DW-1:0]     i015,
   output logic [4:0]        i1620,
   output logic [4:0]        i1115,
   output logic              stall
);

   logic [5:0] w_opcode;
   logic [4:0] w_rs;
   logic [4:0] w_rt;
   logic       w_hazard;
   ctrl_t      w_ctrl_dec;
   ctrl_t      w_ctrl;

   assign w_opcode = instr[31:26];
   assign w_rs     = instr[25:21];
   assign w_rt     = instr[20:16];

   reg_file #(
      .NREGS (NREGS),
      .DW    (DW)
   ) u_reg_file (
      .clk      (clk),
      .rst      (rst),
      .i_we     (wb_we),
      .i_waddr  (wb_addr),
      .i_wdata  (wb_data),
      .i_raddr1 (w_rs),
      .i_raddr2 (w_rt),
      .o_rdata1 (rd1),
      .o_rdata2 (rd2)
   );

   assign w_hazard = ex_memread && (ex_rt != 5'd0) &&
                     ((ex_rt == w_rs) || (ex_rt == w_rt));

   // Bubble: a stalled or reset cycle pushes an all-zero control word into ID/EX
   always_comb begin
      w_ctrl_dec = decode_ctrl(w_opcode);
      w_ctrl     = w_ctrl_dec;
      if (rst || w_hazard) w_ctrl = CTRL_NOP;
   end

   assign RegDst   = w_ctrl.reg_dst;
   assign ALUSrc   = w_ctrl.alu_src;
   assign MemtoReg = w_ctrl.mem_to_reg;
   assign RegWrite = w_ctrl.reg_write;
   assign MemRead  = w_ctrl.mem_read;
   assign MemWrite = w_ctrl.mem_write;
   assign Branch   = w_ctrl.branch;
   assign BranchNE = w_ctrl.branch_ne;
   assign ALUOp    = w_ctrl.alu_op;

   assign stall = !rst && w_hazard;

   assign pc4o  = pc4;
   assign i015  = {{(DW-16){instr[15]}}, instr[15:0]};
   assign i1620 = instr[20:16];
   assign i1115 = instr[15:11];

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// Module : tb_decode_stage
// Desc   : Self-checking bench for decode_stage: directed cases then random
//          traffic against a behavioural model (honours WB_BYPASS_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr, pc4, wb_data, pc4o, rd1, rd2, i015;
   logic        wb_we, ex_memread;
   logic [4:0]  wb_addr, ex_rt, i1620, i1115;
   logic        RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, BranchNE, stall;
   logic [1:0]  ALUOp;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] m_regs [32];
   bit          regs_known = 1'b0;

   always #5 clk = ~clk;

   decode_stage #(.NREGS(32), .DW(32)) dut (
      .clk(clk), .rst(rst), .instr(instr), .pc4(pc4),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_memread(ex_memread), .ex_rt(ex_rt),
      .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .BranchNE(BranchNE),
      .ALUOp(ALUOp), .pc4o(pc4o), .rd1(rd1), .rd2(rd2), .i015(i015),
      .i1620(i1620), .i1115(i1115), .stall(stall)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Control word packed as {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,BranchNE,ALUOp}
   function automatic logic [9:0] ref_ctrl(input logic [5:0] op);
      case (op)
         6'b000000: return 10'b1001_0000_10;
         6'b100011: return 10'b0111_1000_00;
         6'b101011: return 10'b0100_0100_00;
         6'b000100: return 10'b0000_0010_01;
         6'b000101: return 10'b0000_0001_01;
         6'b001000: return 10'b0101_0000_00;
         default:   return 10'b0;
      endcase
   endfunction

   function automatic logic [31:0] ref_read(input logic [4:0] a);
      logic [31:0] v;
      v = (a == 5'd0) ? 32'h0 : m_regs[a];
`ifdef WB_BYPASS_EN
      if (!rst && wb_we && wb_addr != 5'd0 && wb_addr == a) v = wb_data;
`endif
      return v;
   endfunction

   task automatic drive(input logic r, input logic [31:0] in, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd,
                        input logic mr, input logic [4:0] ert);
      rst = r; instr = in; pc4 = $urandom; wb_we = we; wb_addr = wa; wb_data = wd;
      ex_memread = mr; ex_rt = ert;
   endtask

   // Compare every output against the model, sampled at the falling edge
   task automatic settle();
      logic       haz;
      logic [9:0] ec;
      @(negedge clk);
      haz = ex_memread && ex_rt != 5'd0 && (ex_rt == instr[25:21] || ex_rt == instr[20:16]);
      ec  = (rst || haz) ? 10'b0 : ref_ctrl(instr[31:26]);
      check("ctrl", {22'b0, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
                     Branch, BranchNE, ALUOp}, {22'b0, ec});
      check("stall", {31'b0, stall}, {31'b0, !rst && haz});
      check("pc4o", pc4o, pc4);
      check("i015", i015, {{16{instr[15]}}, instr[15:0]});
      check("fields", {22'b0, i1620, i1115}, {22'b0, instr[20:16], instr[15:11]});
      if (regs_known) begin
         check("rd1", rd1, ref_read(instr[25:21]));
         check("rd2", rd2, ref_read(instr[20:16]));
      end
   endtask

   task automatic advance();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
         regs_known = 1'b1;
      end else if (wb_we && wb_addr != 5'd0) begin
         m_regs[wb_addr] = wb_data;
      end
      #1;
   endtask

   function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      return {6'b000000, rs, rt, rd, 5'd0, 6'h20};
   endfunction

   localparam logic [31:0] NOP_I = 32'hFC00_0000;

   initial begin
      logic [5:0]  ops [8];
      logic [31:0] ri;
      ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000, 6'b111111, 6'b010101};

      drive(1, NOP_I, 0, 0, 0, 0, 0);
      #1; settle(); advance();

      // Write/read
      drive(0, NOP_I, 1, 5'd5, 32'hDEADBEEF, 0, 0); settle(); advance();
      drive(0, mk_r(5'd5, 5'd0, 5'd1), 0, 0, 0, 0, 0); settle();
      check("wr_rd1", rd1, 32'hDEADBEEF);
      check("wr_rd2", rd2, 32'h0);
      check("wr_ctrl", {30'b0, RegDst, ALUOp}, 32'b110);
      advance();

      // r0 protection
      drive(0, NOP_I, 1, 5'd0, 32'h1234, 0, 0); settle(); advance();
      drive(0, mk_r(5'd0, 5'd0, 5'd1), 0, 0, 0, 0, 0); settle();
      check("r0_rd1", rd1, 32'h0);
      advance();

      // Same-cycle write-back versus read of r7
      drive(0, mk_r(5'd7, 5'd0, 5'd2), 1, 5'd7, 32'h55, 0, 0); settle();
`ifdef WB_BYPASS_EN
      check("byp_same", rd1, 32'h55);
`else
      check("byp_same", rd1, 32'h0);
`endif
      advance();
      drive(0, mk_r(5'd7, 5'd0, 5'd2), 0, 0, 0, 0, 0); settle();
      check("byp_next", rd1, 32'h55);
      advance();

      // Load-use
      drive(0, mk_r(5'd8, 5'd3, 5'd2), 0, 0, 0, 1, 5'd8); settle();
      check("lu_stall", {31'b0, stall}, 32'd1);
      check("lu_ctrl", {22'b0, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
                        Branch, BranchNE, ALUOp}, 32'd0);
      advance();
      drive(0, mk_r(5'd0, 5'd0, 5'd2), 0, 0, 0, 1, 5'd0); settle();
      check("lu_rt0", {31'b0, stall}, 32'd0);
      advance();
      drive(0, mk_r(5'd4, 5'd3, 5'd2), 0, 0, 0, 1, 5'd8); settle();
      check("lu_nomatch", {31'b0, stall}, 32'd0);
      advance();

      // Decode coverage
      drive(0, 32'h8C220004, 0, 0, 0, 0, 0); settle();
      check("lw_ctrl", {28'b0, ALUSrc, MemtoReg, RegWrite, MemRead}, 32'hF);
      check("lw_imm", i015, 32'h4);
      advance();
      drive(0, 32'h1022FFFC, 0, 0, 0, 0, 0); settle();
      check("beq_imm", i015, 32'hFFFFFFFC);
      check("beq_ctrl", {29'b0, Branch, ALUOp}, 32'b101);
      advance();
      drive(0, NOP_I, 0, 0, 0, 0, 0); settle(); advance();

      // Reset mid-operation
      drive(0, NOP_I, 1, 5'd3, 32'd9, 0, 0); settle(); advance();
      drive(1, 32'h8C640000, 1, 5'd4, 32'hABCD, 1, 5'd3); settle();
      check("rst_stall", {31'b0, stall}, 32'd0);
      check("rst_ctrl", {22'b0, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
                         Branch, BranchNE, ALUOp}, 32'd0);
      advance();
      drive(0, mk_r(5'd3, 5'd4, 5'd1), 0, 0, 0, 0, 0); settle();
      check("rst_r3", rd1, 32'h0);
      check("rst_r4", rd2, 32'h0);
      advance();

      // Random traffic on a narrow register window to provoke hazards and bypass
      for (int n = 0; n < 800; n++) begin
         ri = {ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               16'($urandom)};
         drive(($urandom_range(0, 39) == 0), ri, 1'($urandom), 5'($urandom_range(0, 7)),
               $urandom, 1'($urandom), 5'($urandom_range(0, 7)));
         settle();
         advance();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
